// File: rtl/prim_unpacker_pkg.sv
// prim_unpacker_pkg: FSM state type and count-width helper shared by the unpacker files
package prim_unpacker_pkg;

    typedef enum logic {Idle, Busy} st_e;

    // Number of bits needed to represent values 0 .. value-1, never less than 1.
    function automatic int vbits(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/prim_unpacker_align.sv
// prim_unpacker_align: combinational input aligner
//   data_i   in  InW  raw input data
//   mask_i   in  InW  contiguous input mask
//   lod_o    out CW   index of the lowest set mask bit (0 when mask_i is 0)
//   popcnt_o out CW   number of set mask bits
//   data_o   out InW  masked data shifted down so its lowest kept bit sits at bit 0
module prim_unpacker_align
    import prim_unpacker_pkg::*;
#(
    parameter int InW = 32,
    parameter int CW  = vbits(InW + 1)
) (
    input  logic [InW-1:0] data_i,
    input  logic [InW-1:0] mask_i,
    output logic [CW-1:0]  lod_o,
    output logic [CW-1:0]  popcnt_o,
    output logic [InW-1:0] data_o
);

    logic found;

    always_comb begin
        lod_o    = '0;
        popcnt_o = '0;
        found    = 1'b0;
        for (int i = 0; i < InW; i++) begin
            if (mask_i[i]) begin
                popcnt_o = popcnt_o + CW'(1);
                if (!found) begin
                    lod_o = CW'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign data_o = (data_i & mask_i) >> lod_o;

endmodule

// File: rtl/prim_unpacker.sv
// prim_unpacker: splits one masked InW-bit word into OutW-bit beats, LSB chunk first
//   clk_i    in  1     clock
//   rst_ni   in  1     synchronous active-low reset
//   valid_i  in  1     input word valid
//   data_i   in  InW   input data
//   mask_i   in  InW   contiguous input mask
//   ready_o  out 1     input word accepted when valid_i && ready_o
//   valid_o  out 1     output beat valid
//   data_o   out OutW  output data, unmasked bits zeroed
//   mask_o   out OutW  low-aligned output mask
//   last_o   out 1     final beat of the current word
//   ready_i  in  1     output beat consumed when valid_o && ready_i
//   clear_i  in  1     drop the remnant and return to idle
module prim_unpacker
    import prim_unpacker_pkg::*;
#(
    parameter int InW          = 32,
    parameter int OutW         = 8,
    parameter bit HintByteData = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [InW-1:0]  data_i,
    input  logic [InW-1:0]  mask_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [OutW-1:0] data_o,
    output logic [OutW-1:0] mask_o,
    output logic            last_o,
    input  logic            ready_i,
    input  logic            clear_i
);

    localparam int CW = vbits(InW + 1);

    if (InW < OutW) begin : g_width_err
        $error("prim_unpacker: InW must be >= OutW");
    end

    st_e            st_q, st_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [InW-1:0] stor_q, stor_d;
    logic [CW-1:0]  lod, popcnt;
    logic [InW-1:0] aligned;
    logic           ack_in, ack_out;

    prim_unpacker_align #(.InW(InW), .CW(CW)) u_align (
        .data_i   (data_i),
        .mask_i   (mask_i),
        .lod_o    (lod),
        .popcnt_o (popcnt),
        .data_o   (aligned)
    );

    assign valid_o = cnt_q != '0;
    assign mask_o  = (cnt_q >= CW'(OutW)) ? {OutW{1'b1}} : ~({OutW{1'b1}} << cnt_q);
    assign data_o  = stor_q[OutW-1:0] & mask_o;
    assign last_o  = valid_o && (cnt_q <= CW'(OutW));
    // A new word may enter while the final beat is being consumed, so words stream without a bubble.
    assign ready_o = !clear_i && (cnt_q == '0 || (cnt_q <= CW'(OutW) && ready_i));
    assign ack_in  = valid_i && ready_o;
    assign ack_out = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q   <= Idle;
            cnt_q  <= '0;
            stor_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            stor_q <= stor_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        stor_d = stor_q;
        if (ack_out) begin
            cnt_d  = (cnt_q >= CW'(OutW)) ? cnt_q - CW'(OutW) : '0;
            stor_d = stor_q >> OutW;
        end
        // Loading after the shift lets a final-beat ack_out and ack_in share a cycle.
        if (ack_in) begin
            cnt_d  = popcnt;
            stor_d = aligned;
        end
        if (clear_i) begin
            cnt_d  = '0;
            stor_d = '0;
        end
        st_d = (cnt_d != '0) ? Busy : Idle;
    end

    logic [InW-1:0] mask_al;
    assign mask_al = mask_i >> lod;

    a_mask_contig: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_i |-> ((mask_al & (mask_al + 1'b1)) == '0));
    a_in_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_i && !ready_o |=> $stable(data_i) && $stable(mask_i));
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o && !ready_i && !clear_i |=> $stable(data_o) && $stable(mask_o) && $stable(last_o));
    a_clear_no_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        clear_i |-> !valid_i);
    a_st_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (st_q == Busy) == (cnt_q != '0));

    if (HintByteData) begin : g_byte
        if (InW % 8 != 0 || OutW % 8 != 0) begin : g_byte_err
            $error("prim_unpacker: HintByteData requires byte-multiple widths");
        end
        for (genvar g = 0; g < InW / 8; g++) begin : g_lane
            a_lane: assert property (@(posedge clk_i) disable iff (!rst_ni)
                valid_i |-> (mask_i[8*g +: 8] == 8'h00 || mask_i[8*g +: 8] == 8'hFF));
        end
    end

endmodule

// File: tb/tb_prim_unpacker.sv
// tb_prim_unpacker: randomized and directed checks of prim_unpacker against a beat-list model
module tb_prim_unpacker;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] m;
        logic       l;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [31:0] mask_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic [7:0]  data_o;
    logic [7:0]  mask_o;
    logic        last_o;
    logic        ready_i = 1'b0;
    logic        clear_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t       exp_q[$];
    logic [31:0] in_d[$];
    logic [31:0] in_m[$];

    prim_unpacker #(.InW(32), .OutW(8), .HintByteData(1'b0)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .data_i  (data_i),
        .mask_i  (mask_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .mask_o  (mask_o),
        .last_o  (last_o),
        .ready_i (ready_i),
        .clear_i (clear_i)
    );

    always #5 clk_i = ~clk_i;

    // Expected beats of one word: gather the kept bits, right-align, cut into 8-bit chunks.
    function automatic void push_word(input logic [31:0] d, input logic [31:0] m);
        logic [31:0] v;
        int          lo;
        int          n;
        int          rem;
        beat_t       b;
        n = $countones(m);
        if (n == 0) return;
        lo = 0;
        while (!m[lo]) lo++;
        v = (d & m) >> lo;
        for (int k = 0; k < n; k += 8) begin
            rem = n - k;
            b.m = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            b.d = v[k +: 8] & b.m;
            b.l = (rem <= 8);
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [31:0] rand_mask();
        int lo;
        int len;
        logic [63:0] w;
        lo  = $urandom_range(31);
        len = $urandom_range(32 - lo);
        if ($urandom_range(9) == 0) begin
            lo  = 0;
            len = 32;
        end
        w = ((64'd1 << len) - 64'd1) << lo;
        return w[31:0];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drives queued words with random valid/ready and checks every beat against the model.
    task automatic run_engine(input string name, input int vld_pct, input int rdy_pct);
        int   guard;
        logic vhold;
        logic exp_rdy;
        beat_t b;
        guard = 0;
        vhold = 1'b0;
        while ((in_d.size() != 0 || exp_q.size() != 0) && guard < 2000) begin
            guard++;
            valid_i = (in_d.size() != 0) && (vhold || $urandom_range(99) < vld_pct);
            if (in_d.size() != 0) begin
                data_i = in_d[0];
                mask_i = in_m[0];
            end
            ready_i = $urandom_range(99) < rdy_pct;
            @(negedge clk_i);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ready_i);
            n_cmp++;
            if (valid_o !== (exp_q.size() != 0)) begin
                n_bad++;
                $display("FAIL %s valid_o: got %b want %b", name, valid_o, exp_q.size() != 0);
            end
            n_cmp++;
            if (ready_o !== exp_rdy) begin
                n_bad++;
                $display("FAIL %s ready_o: got %b want %b", name, ready_o, exp_rdy);
            end
            if (exp_q.size() != 0) begin
                b = exp_q[0];
                n_cmp++;
                if ({data_o, mask_o, last_o} !== {b.d, b.m, b.l}) begin
                    n_bad++;
                    $display("FAIL %s beat: got d=%h m=%h l=%b want d=%h m=%h l=%b",
                             name, data_o, mask_o, last_o, b.d, b.m, b.l);
                end
                if (ready_i) void'(exp_q.pop_front());
            end
            vhold = valid_i && !exp_rdy;
            if (valid_i && exp_rdy) begin
                push_word(in_d[0], in_m[0]);
                void'(in_d.pop_front());
                void'(in_m.pop_front());
            end
            tick();
        end
        valid_i = 1'b0;
        n_cmp++;
        if (guard >= 2000) begin
            n_bad++;
            $display("FAIL %s timeout: %0d words and %0d beats left, want 0", name, in_d.size(), exp_q.size());
            in_d.delete();
            in_m.delete();
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk_i);
        n_cmp++;
        if ({valid_o, data_o, mask_o, last_o, ready_o} !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL %s idle: got v=%b d=%h m=%h l=%b r=%b want v=0 d=00 m=00 l=0 r=1",
                     name, valid_o, data_o, mask_o, last_o, ready_o);
        end
    endtask

    task automatic load_full(input logic [31:0] d);
        valid_i = 1'b1;
        data_i  = d;
        mask_i  = 32'hFFFF_FFFF;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic check_beat(input string name, input logic [7:0] d, input logic rdy);
        @(negedge clk_i);
        n_cmp++;
        if ({valid_o, data_o, ready_o} !== {1'b1, d, rdy}) begin
            n_bad++;
            $display("FAIL %s: got v=%b d=%h r=%b want v=1 d=%h r=%b", name, valid_o, data_o, ready_o, d, rdy);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        check_idle("reset");
        tick();
    endtask

    task automatic test_full_back_to_back();
        in_d = '{32'hAABB_CCDD, 32'h1234_5678};
        in_m = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_engine("full_b2b", 100, 100);
    endtask

    task automatic test_middle_mask();
        in_d = '{32'h1122_3344};
        in_m = '{32'h00FF_FF00};
        run_engine("middle", 100, 100);
    endtask

    task automatic test_partial();
        in_d = '{32'h0000_0ABC};
        in_m = '{32'h0000_0FFF};
        run_engine("partial", 100, 100);
    endtask

    task automatic test_backpressure();
        ready_i = 1'b1;
        load_full(32'hAABB_CCDD);
        check_beat("bp DD", 8'hDD, 1'b0);
        tick();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("bp stall CC", 8'hCC, 1'b0);
            tick();
        end
        ready_i = 1'b1;
        check_beat("bp CC", 8'hCC, 1'b0);
        tick();
        check_beat("bp BB", 8'hBB, 1'b0);
        tick();
        check_beat("bp AA", 8'hAA, 1'b1);
        tick();
        check_idle("bp end");
    endtask

    task automatic test_clear();
        ready_i = 1'b1;
        load_full(32'hAABB_CCDD);
        check_beat("clr DD", 8'hDD, 1'b0);
        tick();
        clear_i = 1'b1;
        ready_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL clr ready_o during clear: got %b want 0", ready_o);
        end
        tick();
        clear_i = 1'b0;
        check_idle("clr after");
        tick();
        in_d = '{32'h1122_3344};
        in_m = '{32'h00FF_FF00};
        run_engine("clr refill", 100, 100);
    endtask

    task automatic test_zero_mask_reset();
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'hDEAD_BEEF;
        mask_i  = 32'h0;
        @(negedge clk_i);
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL zero mask ready_o: got %b want 1", ready_o);
        end
        tick();
        valid_i = 1'b0;
        check_idle("zero mask");
        tick();
        load_full(32'h5566_7788);
        check_beat("rst 88", 8'h88, 1'b0);
        tick();
        check_beat("rst 77", 8'h77, 1'b0);
        rst_ni = 1'b0;
        tick();
        check_idle("mid reset");
        rst_ni = 1'b1;
        tick();
        in_d = '{32'h0000_0ABC};
        in_m = '{32'h0000_0FFF};
        run_engine("post reset", 100, 100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            in_d.push_back($urandom);
            in_m.push_back(rand_mask());
        end
        run_engine("random", 60, 70);
        for (int i = 0; i < 30; i++) begin
            in_d.push_back($urandom);
            in_m.push_back(rand_mask());
        end
        run_engine("random_b2b", 100, 100);
    endtask

    initial begin
        test_reset();
        test_full_back_to_back();
        test_middle_mask();
        test_partial();
        test_backpressure();
        test_clear();
        test_zero_mask_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
